// File: rtl/spinner_pkg.sv
// rtl/spinner_pkg.sv - shared widths, types and helpers for the spinner accelerator
package spinner_pkg;

  localparam int ACC_W  = 12;
  localparam int FRAC_W = 4;

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [7:0]       speed_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_BTN, SRC_ANALOG} src_e;

  // Magnitude of a signed 8-bit axis; -128 comes out as 128, which still fits unsigned.
  function automatic speed_t abs8(input logic [7:0] v);
    abs8 = v[7] ? speed_t'(8'd0 - v) : v;
  endfunction

endpackage

// File: rtl/spinner_speed_ramp.sv
// rtl/spinner_speed_ramp.sv - per-frame step size, speed ramp and last-motion direction
// Restarts the ramp on reversal, idle or analog use; ramps after the add while a button is held.
module spinner_speed_ramp
  import spinner_pkg::*;
#(
  parameter int SPEED_MIN  = 16,
  parameter int SPEED_MAX  = 128,
  parameter int SPEED_STEP = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   tick_i,
  input  src_e   src_i,
  input  logic   dir_req_i,
  input  logic   use_spinner_i,
  input  speed_t analog_step_i,
  output speed_t step_o,
  output logic   dir_o
);

  localparam speed_t MIN_S = speed_t'(SPEED_MIN);
  localparam speed_t MAX_S = speed_t'(SPEED_MAX);

  speed_t     speed_q, speed_d;
  logic       dir_q, dir_d;
  speed_t     base;
  logic       reversal;
  logic       speed_reset;
  logic [8:0] ramp_sum;

  always_comb begin
    step_o      = '0;
    speed_d     = speed_q;
    dir_d       = dir_q;
    reversal    = 1'b0;
    speed_reset = 1'b0;
    base        = speed_q;
    ramp_sum    = '0;
    case (src_i)
      SRC_ANALOG: begin
        step_o      = analog_step_i;
        speed_reset = 1'b1;
      end
      SRC_BTN: begin
        if (use_spinner_i) begin
          reversal = (dir_req_i != dir_q);
          base     = reversal ? MIN_S : speed_q;
          step_o   = base;
          ramp_sum = {1'b0, base} + 9'(SPEED_STEP);
          speed_d  = (ramp_sum > 9'(SPEED_MAX)) ? MAX_S : ramp_sum[7:0];
        end else begin
          step_o = MAX_S;
        end
      end
      default: speed_reset = 1'b1;
    endcase
    if (speed_reset) speed_d = MIN_S;
    if (step_o != '0) dir_d = dir_req_i;
    // Only a frame tick may commit; between ticks everything holds.
    if (!tick_i) begin
      speed_d = speed_q;
      dir_d   = dir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      speed_q <= MIN_S;
      dir_q   <= 1'b0;
    end else begin
      speed_q <= speed_d;
      dir_q   <= dir_d;
    end
  end

  assign dir_o = dir_q;

endmodule

// File: rtl/spinner_accel.sv
// rtl/spinner_accel.sv - button/analog to 8-bit spinner angle, updated once per vsync
// SPINNER_CLAMP_EN: saturate the accumulator at 0/4095 instead of wrapping.
module spinner_accel
  import spinner_pkg::*;
#(
  parameter int SPEED_MIN    = 16,
  parameter int SPEED_MAX    = 128,
  parameter int SPEED_STEP   = 4,
  parameter int ANALOG_DZ    = 8,
  parameter int ANALOG_SHIFT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       plus,
  input  logic       minus,
  input  logic       strobe,
  input  logic       use_spinner,
  input  logic [7:0] analog,
  output logic [7:0] spin_angle,
  output logic       moving,
  output logic       dir
);

  logic       strobe_q;
  logic       tick;
  acc_t       acc_q, acc_d;
  logic       moving_q, moving_d;
  speed_t     analog_mag;
  speed_t     analog_step;
  speed_t     step;
  src_e       src;
  logic       dir_req;
  logic [ACC_W:0] sum_up, sum_dn;

  assign tick        = strobe & ~strobe_q;
  assign analog_mag  = abs8(analog);
  assign analog_step = analog_mag >> ANALOG_SHIFT;

  // Analog outside the deadzone overrides the buttons entirely.
  always_comb begin
    src     = SRC_NONE;
    dir_req = plus;
    if (analog_mag > speed_t'(ANALOG_DZ)) begin
      src     = SRC_ANALOG;
      dir_req = ~analog[7];
    end else if (plus ^ minus) begin
      src = SRC_BTN;
    end
  end

  spinner_speed_ramp #(
    .SPEED_MIN  (SPEED_MIN),
    .SPEED_MAX  (SPEED_MAX),
    .SPEED_STEP (SPEED_STEP)
  ) u_ramp (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_i        (tick),
    .src_i         (src),
    .dir_req_i     (dir_req),
    .use_spinner_i (use_spinner),
    .analog_step_i (analog_step),
    .step_o        (step),
    .dir_o         (dir)
  );

  assign sum_up = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, step};
  assign sum_dn = {1'b0, acc_q} - {{(ACC_W + 1 - 8){1'b0}}, step};

  always_comb begin
    acc_d    = acc_q;
    moving_d = moving_q;
    if (tick) begin
      moving_d = (step != '0);
`ifdef SPINNER_CLAMP_EN
      if (dir_req) acc_d = sum_up[ACC_W] ? '1 : sum_up[ACC_W-1:0];
      else         acc_d = sum_dn[ACC_W] ? '0 : sum_dn[ACC_W-1:0];
`else
      acc_d = dir_req ? sum_up[ACC_W-1:0] : sum_dn[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      acc_q    <= '0;
      moving_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
      acc_q    <= acc_d;
      moving_q <= moving_d;
    end
  end

  assign spin_angle = acc_q[ACC_W-1:FRAC_W];
  assign moving     = moving_q;

endmodule

// File: tb/tb_spinner_accel.sv
// tb/tb_spinner_accel.sv - directed vectors for spinner_accel (honours SPINNER_CLAMP_EN)
module tb_spinner_accel;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       plus = 1'b0;
  logic       minus = 1'b0;
  logic       strobe = 1'b0;
  logic       use_spinner = 1'b1;
  logic [7:0] analog = 8'd0;
  logic [7:0] spin_angle;
  logic       moving;
  logic       dir;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spinner_accel dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .plus        (plus),
    .minus       (minus),
    .strobe      (strobe),
    .use_spinner (use_spinner),
    .analog      (analog),
    .spin_angle  (spin_angle),
    .moving      (moving),
    .dir         (dir)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; plus = 1'b0; minus = 1'b0; strobe = 1'b0;
    analog = 8'd0; use_spinner = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk); strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    do_reset();
    check_eq("rst_angle", spin_angle, 0);
    check_eq("rst_moving", moving, 0);
    check_eq("rst_dir", dir, 0);

    // Accelerated plus: acc 16, 36, 60
    plus = 1'b1;
    frame(); check_eq("ramp_t1", spin_angle, 1);
    frame(); check_eq("ramp_t2", spin_angle, 2);
    frame(); check_eq("ramp_t3", spin_angle, 3);
    check_eq("ramp_dir", dir, 1);
    check_eq("ramp_moving", moving, 1);

    // Underflow from zero
    do_reset();
    minus = 1'b1;
    frame();
`ifdef SPINNER_CLAMP_EN
    check_eq("minus_from0", spin_angle, 0);
`else
    check_eq("minus_from0", spin_angle, 255);
`endif
    check_eq("minus_dir", dir, 0);
    check_eq("minus_moving", moving, 1);

    // Button mode: fixed 128 per frame, no ramp on reversal
    do_reset();
    use_spinner = 1'b0; plus = 1'b1;
    frame(); check_eq("btn_t1", spin_angle, 8);
    frame(); check_eq("btn_t2", spin_angle, 16);
    plus = 1'b0; minus = 1'b1;
    frame(); check_eq("btn_rev", spin_angle, 8);
    check_eq("btn_rev_dir", dir, 0);

    // Analog path and deadzone boundary
    do_reset();
    analog = 8'd100;
    frame(); check_eq("ana_100", spin_angle, 3);
    check_eq("ana_100_dir", dir, 1);
    analog = 8'hFB; plus = 1'b1;
    frame(); check_eq("ana_dz_btn", spin_angle, 4);
    analog = 8'd9; plus = 1'b0;
    frame(); check_eq("ana_9_moving", moving, 1);
    check_eq("ana_9_angle", spin_angle, 4);
    analog = 8'd8;
    frame(); check_eq("ana_8_moving", moving, 0);

    do_reset();
    analog = 8'h80;
    frame();
`ifdef SPINNER_CLAMP_EN
    check_eq("ana_m128", spin_angle, 0);
`else
    check_eq("ana_m128", spin_angle, 252);
`endif
    check_eq("ana_m128_dir", dir, 0);

    // Both held: idle, speed restarts; then held strobe ticks once
    do_reset();
    plus = 1'b1;
    repeat (4) frame();
    check_eq("pre_both", spin_angle, 5);
    minus = 1'b1;
    frame(); frame();
    check_eq("both_angle", spin_angle, 5);
    check_eq("both_moving", moving, 0);
    check_eq("both_dir", dir, 1);
    minus = 1'b0;
    frame(); check_eq("after_both", spin_angle, 6);
    @(negedge clk); strobe = 1'b1;
    repeat (1000) @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("strobe_held", spin_angle, 7);

    // Reset coincident with the 10th tick of a ramp
    do_reset();
    plus = 1'b1;
    repeat (9) frame();
    check_eq("ramp9", spin_angle, 18);
    @(negedge clk); strobe = 1'b1; reset_n = 1'b0;
    @(negedge clk); strobe = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_angle", spin_angle, 0);
    check_eq("midrst_moving", moving, 0);
    frame(); check_eq("midrst_next", spin_angle, 1);

    // Ceiling at 128, then reversal restarts at 16
    do_reset();
    plus = 1'b1;
    repeat (32) frame();
    check_eq("ceiling", spin_angle, 154);
    plus = 1'b0; minus = 1'b1;
    frame(); check_eq("rev_restart", spin_angle, 153);
    check_eq("rev_dir", dir, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
